// File: rtl/sram_ctrl_pkg.sv
// Shared types for the sram_ctrl request-side controller: FSM states and the
// command payload carried from the request port (or command queue) to the SRAM.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W = 8;
  localparam int unsigned SRAM_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_CAP,
    RSP
  } state_e;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/sram_ctrl_cmdq.sv
// Synchronous command FIFO for sram_ctrl; extra pointer MSB separates full from empty.
// Only instantiated when SRAM_CTRL_CMDQ_EN is defined.
module sram_ctrl_cmdq
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  cmd_t push_data_i,
  input  logic pop_i,
  output cmd_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;
  cmd_t             mem_q [DEPTH];

  assign full_o  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[IDX_W-1:0]];

  // A full queue may still accept when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Sole master of a 256x8 single-port SRAM: sequences addr/rw/shared data bus and
// returns read data on a valid/ready channel. SRAM_CTRL_CMDQ_EN adds a command FIFO.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_W,
  parameter int unsigned DATA_W = SRAM_DATA_W
`ifdef SRAM_CTRL_CMDQ_EN
  , parameter int unsigned CMDQ_DEPTH = 4
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rw_o,
  inout  wire  [DATA_W-1:0] mem_data_io
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rw_q, mem_rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  cmd_t              req_cmd_c;
  cmd_t              cmd_c;
  logic              cmd_avail_c;
  logic              issue_c;

  assign req_cmd_c = {req_we_i, SRAM_ADDR_W'(req_addr_i), SRAM_DATA_W'(req_wdata_i)};

`ifdef SRAM_CTRL_CMDQ_EN
  logic q_full, q_empty;

  assign req_ready_o = (!q_full || issue_c) && !rst_i;
  assign cmd_avail_c = !q_empty;

  sram_ctrl_cmdq #(
    .DEPTH (CMDQ_DEPTH)
  ) u_cmdq (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (req_valid_i && req_ready_o),
    .push_data_i (req_cmd_c),
    .pop_i       (issue_c),
    .head_o      (cmd_c),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );
`else
  // Without a queue the request issues on its own acceptance edge.
  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign cmd_avail_c = req_valid_i && req_ready_o;
  assign cmd_c       = req_cmd_c;
`endif

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_rw_d    = 1'b0;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    issue_c     = 1'b0;

    case (state_q)
      IDLE: issue_c = cmd_avail_c;
      WR: begin
        if (cmd_avail_c) issue_c = 1'b1;
        else             state_d = IDLE;
      end
      RD: state_d = RD_CAP;
      RD_CAP: begin
        rsp_rdata_d = mem_data_io;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (cmd_avail_c) issue_c = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Load the SRAM address/direction for the command leaving the head.
    if (issue_c) begin
      mem_addr_d = ADDR_W'(cmd_c.addr);
      wdata_d    = DATA_W'(cmd_c.wdata);
      mem_rw_d   = cmd_c.we;
      state_d    = cmd_c.we ? WR : RD;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_rw_q    <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_rw_q    <= mem_rw_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_rw_o    = mem_rw_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_data_io = mem_rw_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural 256x8 single-port SRAM on the
// shared bus; vector table plus hand-written stall/reset/queue sequences.
module tb_sram_ctrl;

`ifdef SRAM_CTRL_CMDQ_EN
  localparam int EXP_RD_LAT = 3;
`else
  localparam int EXP_RD_LAT = 2;
`endif

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic [7:0] mem_addr;
  logic       mem_rw;
  wire  [7:0] mem_data;

  int n_total = 0;
  int n_pass  = 0;

  sram_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .mem_addr_o  (mem_addr),
    .mem_rw_o    (mem_rw),
    .mem_data_io (mem_data)
  );

  // SRAM model: write on rw=1 edges, registered read otherwise, drives bus while rw=0.
  logic [7:0] sram_mem [256];
  logic [7:0] sram_q;
  always @(posedge clk) begin
    if (mem_rw) sram_mem[mem_addr] <= mem_data;
    else        sram_q <= sram_mem[mem_addr];
  end
  assign mem_data = mem_rw ? 8'hzz : sram_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int b = 0;
    while (!req_ready && b < 50) begin
      tick();
      b++;
    end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic issue_write(input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    wait_ready();
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
`ifdef SRAM_CTRL_CMDQ_EN
    tick();
`endif
  endtask

  task automatic read_req(input logic [7:0] a, output logic [7:0] data, output int lat);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    wait_ready();
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    data = rsp_rdata;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    int         lat;
    int         b;

    vecs[0]  = '{1'b1, 8'h10, 8'hA5};
    vecs[1]  = '{1'b0, 8'h10, 8'hA5};
    vecs[2]  = '{1'b1, 8'h11, 8'h3C};
    vecs[3]  = '{1'b1, 8'h12, 8'hC3};
    vecs[4]  = '{1'b0, 8'h11, 8'h3C};
    vecs[5]  = '{1'b0, 8'h12, 8'hC3};
    vecs[6]  = '{1'b1, 8'h10, 8'h00};
    vecs[7]  = '{1'b0, 8'h10, 8'h00};
    vecs[8]  = '{1'b1, 8'hFF, 8'hFF};
    vecs[9]  = '{1'b0, 8'hFF, 8'hFF};
    vecs[10] = '{1'b0, 8'h12, 8'hC3};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    rsp_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mem_rw", 32'(mem_rw), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
    end
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Vector table: writes check the bus on their commit cycle, reads check data and latency.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].we) begin
        issue_write(vecs[i].addr, vecs[i].data);
        check("vec_wr_rw", 32'(mem_rw), 32'd1);
        check("vec_wr_addr", 32'(mem_addr), 32'(vecs[i].addr));
        check("vec_wr_bus", 32'(mem_data), 32'(vecs[i].data));
        tick();
        check("vec_wr_release", 32'(mem_rw), 32'd0);
      end else begin
        read_req(vecs[i].addr, rd, lat);
        check("vec_rd_lat", 32'(lat), 32'(EXP_RD_LAT));
        check("vec_rd_data", 32'(rd), 32'(vecs[i].data));
      end
    end

    for (int i = 0; i < 256; i++) issue_write(8'(i), 8'(i));
    for (int i = 0; i < 256; i++) begin
      read_req(8'(i), rd, lat);
      check("sweep_rd", 32'(rd), 32'(i));
    end

    // Response stall with a write waiting behind it.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h20;
    wait_ready();
    tick();
    req_we    = 1'b1;
    req_addr  = 8'h21;
    req_wdata = 8'h5A;
`ifdef SRAM_CTRL_CMDQ_EN
    wait_ready();
    tick();
    req_valid = 1'b0;
`endif
    b = 0;
    while (!rsp_valid && b < 20) begin
      tick();
      b++;
    end
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_rdata", 32'(rsp_rdata), 32'h20);
      check("stall_no_issue", 32'(mem_rw), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("stall_ack_valid", 32'(rsp_valid), 32'd0);
`ifndef SRAM_CTRL_CMDQ_EN
    check("stall_ack_no_rw", 32'(mem_rw), 32'd0);
    wait_ready();
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
`endif
    check("stall_wr_rw", 32'(mem_rw), 32'd1);
    check("stall_wr_addr", 32'(mem_addr), 32'h21);
    req_we = 1'b0;
    read_req(8'h21, rd, lat);
    check("stall_wr_readback", 32'(rd), 32'h5A);

`ifdef SRAM_CTRL_CMDQ_EN
    // Fill the queue behind a stalled response, then drain as back-to-back writes.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h40;
    wait_ready();
    tick();
    req_valid = 1'b0;
    b = 0;
    while (!rsp_valid && b < 20) begin
      tick();
      b++;
    end
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 8'(8'h50 + k);
      req_wdata = 8'(8'hB0 + k);
      check("q_push_ready", 32'(req_ready), 32'd1);
      tick();
    end
    req_addr  = 8'h54;
    req_wdata = 8'hB4;
    check("q_full_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    req_we    = 1'b0;
    check("q_rsp_rdata", 32'(rsp_rdata), 32'h40);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("q_drain_rw", 32'(mem_rw), 32'd1);
      check("q_drain_addr", 32'(mem_addr), 32'(8'h50 + k));
      check("q_drain_bus", 32'(mem_data), 32'(8'hB0 + k));
      tick();
    end
    check("q_drain_done", 32'(mem_rw), 32'd0);
    for (int k = 0; k < 4; k++) begin
      read_req(8'(8'h50 + k), rd, lat);
      check("q_readback", 32'(rd), 32'(8'hB0 + k));
    end
`endif

    // Reset while a write is on the bus must drop it before its commit edge.
    issue_write(8'h30, 8'h77);
    check("rst_wr_rw_before", 32'(mem_rw), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_wr_rw_async", 32'(mem_rw), 32'd0);
    check("rst_wr_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    check("rst_wr_rw_hold", 32'(mem_rw), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_wr_ready_after", 32'(req_ready), 32'd1);
    read_req(8'h30, rd, lat);
    check("rst_wr_not_committed", 32'(rd), 32'h30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
